// File: rtl/sprite_loader_if.sv
// Bus between the SPI byte receiver, the sprite RAM write port and the sprite loader.
// The loader is the slave and the SPI/RAM side is the master.
interface sprite_loader_if #(
  parameter int SPRITES  = 8,
  parameter int PIX_BITS = 12
);
  localparam int SLOT_BITS = $clog2(SPRITES);
  localparam int ADDR_W    = SLOT_BITS + PIX_BITS;

  // byte_valid is a one-cycle strobe with no ready: the loader must take the
  // byte in that cycle or drop it (and flag overrun); there is no backpressure.
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                frame_abort;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [3:0]          ram_d;
  logic                busy;
  logic                done;
  logic [SPRITES-1:0]  loaded;
  logic                overrun;
  logic [1:0]          state_dbg;

  modport master (
    output byte_valid, byte_data, frame_abort,
    input  ram_we, ram_addr, ram_d, busy, done, loaded, overrun, state_dbg
  );

  modport slave (
    input  byte_valid, byte_data, frame_abort,
    output ram_we, ram_addr, ram_d, busy, done, loaded, overrun, state_dbg
  );
endinterface

// File: rtl/sprite_loader.sv
// Write-side controller for the sprite RAM: decodes a slot header, unpacks data
// bytes into two pixels each and tracks which slots hold a complete image.
module sprite_loader #(
  parameter int SPRITES  = 8,
  parameter int PIX_BITS = 12
) (
  input  logic            clk,
  input  logic            reset,
  sprite_loader_if.slave  bus
);
  localparam int SLOT_BITS = $clog2(SPRITES);
  localparam int ADDR_W    = SLOT_BITS + PIX_BITS;
  localparam logic [PIX_BITS-1:0] LAST_PIX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WR_LO = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [PIX_BITS-1:0]  count_q, count_d;
  logic [PIX_BITS-1:0]  count_inc;
  logic [3:0]           lo_q, lo_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [3:0]           d_q, d_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SPRITES-1:0]   loaded_q, loaded_d;
  logic                 ovr_q, ovr_d;

  assign count_inc = count_q + PIX_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      count_q  <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    count_d  = count_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    d_d      = d_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (bus.byte_valid && bus.byte_data[7] && !bus.frame_abort) begin
          slot_d   = bus.byte_data[SLOT_BITS-1:0];
          count_d  = '0;
          loaded_d[bus.byte_data[SLOT_BITS-1:0]] = 1'b0;
          ovr_d    = 1'b0;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (bus.frame_abort) begin
          state_d = IDLE;
        end else if (bus.byte_valid) begin
          we_d    = 1'b1;
          addr_d  = {slot_q, count_q};
          d_d     = bus.byte_data[7:4];
          lo_d    = bus.byte_data[3:0];
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        // Abort here discards the held low nibble; no write is issued.
        if (bus.frame_abort) begin
          state_d = IDLE;
        end else begin
          if (bus.byte_valid) ovr_d = 1'b1;
          we_d    = 1'b1;
          addr_d  = {slot_q, count_inc};
          d_d     = lo_q;
          count_d = count_q + PIX_BITS'(2);
          if (count_inc == LAST_PIX) begin
            done_d           = 1'b1;
            loaded_d[slot_q] = 1'b1;
            state_d          = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // busy also covers the cycle carrying the final write and done pulse.
    busy_d = (state_d != IDLE) || done_d;
  end

  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_d     = d_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.loaded    = loaded_q;
  assign bus.overrun   = ovr_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/sprite_loader.md
# sprite_loader

Write-side controller for the 32768 x 4-bit dual-port sprite RAM (8 sprites, 64x64 pixels each). It takes bytes from the SPI slave as single-cycle strobes and decodes a per-sprite load command. It unpacks each data byte into two 4-bit pixels and drives the RAM write port with sequential addresses inside the selected sprite slot. It also tracks which sprite slots hold a complete image, so display logic can ignore slots that are only partially written.

## Interface
- SPRITES, 8: number of sprite slots; the slot index is 3 bits.
- PIX_BITS, 12: log2 of pixels per sprite (64x64 = 4096).
- clk  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe: byte_data holds a new received byte.
- byte_data  in  8  received SPI byte.
- frame_abort  in  1  one-cycle pulse when chip-select deasserts; ends any transfer in progress.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  15  RAM write address, {slot[2:0], pixel[11:0]}, registered.
- ram_d  out  4  RAM write data, registered.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse after the last pixel of a load has been written.
- loaded  out  8  bit i high means slot i holds a complete image.
- overrun  out  1  sticky flag: a data byte was dropped.

## Operation
- States: IDLE, RECV, WR_LO.
- **Header byte**
  - Valid only in IDLE, when byte_valid=1 and byte_data[7]=1. byte_data[2:0] is the slot; byte_data[6:3] are ignored.
  - On accept: latch slot, clear the pixel counter to 0, clear loaded[slot], clear overrun, go to RECV.
  - A byte with bit7=0 in IDLE is ignored with no state change.
- **Data byte**
  - A data byte arrives in RECV with byte_valid=1.
  - Next cycle: ram_we=1, ram_addr={slot,count}, ram_d=byte_data[7:4]. Hold the low nibble; go to WR_LO.
  - WR_LO cycle: ram_we=1, ram_addr={slot,count+1}, ram_d=held[3:0]. count advances by 2.
  - If count+1 = 4095 in that cycle, the next state is IDLE and done pulses; otherwise the next state is RECV.
- **Completion**
  - When done pulses, loaded[slot] sets in the same cycle.
  - The counter is 12 bits and never wraps inside a load; completion at pixel 4095 always ends the load.
- **Overrun**
  - byte_valid in WR_LO drops the byte and sets overrun.
  - The load continues; the pixel count does not advance for the dropped byte.
- **Abort**
  - frame_abort in any non-IDLE state moves to IDLE next cycle and forces ram_we=0 from that cycle on. A pending low-nibble write is discarded.
  - loaded[slot] stays 0 and done does not pulse.
  - frame_abort in IDLE has no effect.
- **Simultaneous events**
  - frame_abort together with byte_valid: abort wins and the byte is ignored.
  - A header byte arriving in RECV is treated as data, since bit7 has no meaning there.
- **Reset** (including mid-load)
  - State returns to IDLE.
  - All outputs go to 0: ram_we=0, ram_addr=0, ram_d=0, busy=0, done=0, loaded=8'h00, overrun=0.
  - No RAM write is issued in the cycle after reset.

## Timing
- Header strobe in cycle N: busy=1 from N+1.
- Data strobe in cycle M: writes occur in cycles M+1 (high nibble) and M+2 (low nibble).
- Last data strobe in cycle M: the final write is in M+2, done=1 and loaded[slot]=1 in M+2, busy=0 in M+3.
- Minimum byte spacing without overrun is 2 cycles. SPI delivers one byte per 8 sck periods, so this holds whenever clk is at least 4x sck.
- ram_we is never high for more than 2 consecutive cycles per byte.
- Writes are always to ascending addresses within one slot.
- busy is the registered decode of state != IDLE.

## Test plan
- **Full load:** header 8'h83 followed by 2048 bytes 8'hA5 spaced 4 cycles.
  - 4096 writes to 0x3000..0x3FFF, alternating data 4'hA and 4'h5.
  - The last write is to 0x3FFF; done pulses once; loaded=8'h08; overrun=0.
- **Ignored header:** byte 8'h03 in IDLE, then 8'h85.
  - The first byte is ignored.
  - The load targets slot 5, and its first write is at 0x5000 with data from the byte following 8'h85.
- **Abort mid-load:** load slot 7 (loaded[7] previously 1), send 100 data bytes, then pulse frame_abort.
  - Exactly 200 writes, 0x7000..0x70C7.
  - loaded[7]=0, no done pulse, busy=0 the cycle after the abort.
- **Overrun:** during a load of slot 0, two byte_valid strobes in consecutive cycles.
  - The second byte is dropped and overrun=1.
  - The next properly spaced byte writes at count+2. The next header clears overrun.
- **Reset mid-load:** assert reset during WR_LO.
  - Next cycle all outputs are 0 and no write occurs.
  - A new header 8'h81 starts cleanly at 0x1000.
- **Abort together with the final byte:** frame_abort coincides with the 2048th byte_valid of a slot-2 load.
  - The byte is ignored; no writes at 0x2FFE or 0x2FFF.
  - No done pulse, and loaded[2] stays 0.
